// File: rtl/uart_tx_stream.sv
// UART transmitter that pulls words from a first-word-fall-through FIFO and sends
// 8N1-style frames (start, DBIT data bits LSB first, SB_TICK/16 stop bits) at 16x oversampling.
module uart_tx_stream #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tx_en,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy
);

    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic            tx_q, tx_d;
    logic            tick;

    // Tick counter only runs while a frame is active, so every frame starts phase-aligned.
    assign tick = (state_q != IDLE) && (cnt_q == CW'(DVSR - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        fifo_rd = 1'b0;
        tx_d    = 1'b1;

        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (tx_en && !fifo_empty && !reset) begin
                    fifo_rd = 1'b1;
                    b_d     = fifo_r_data;
                    s_d     = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        n_d     = '0;
                        state_d = DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = b_q >> 1;
                        if (n_q == NW'(DBIT - 1)) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        s_d     = '0;
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered so tx stays aligned with tx_busy.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = b_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: FIFO models feed two instances (DVSR=4/SB16 and DVSR=2/SB32);
// a line monitor decodes frames and compares them against a queue of pushed words.
module tb_uart_tx_stream;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en0 = 1'b1, en1 = 1'b1;
    logic       fifo_empty0 = 1'b1, fifo_empty1 = 1'b1;
    logic [7:0] fifo_data0 = '0, fifo_data1 = '0;
    logic       fifo_rd0, fifo_rd1;
    logic       tx_w [2];
    logic       busy_w [2];

    logic [7:0] fifo0[$], fifo1[$], exp0[$], exp1[$];
    logic       pend0 = 1'b0, pend1 = 1'b0;
    int         cyc = 0;
    int         rdcnt0 = 0, rdcnt1 = 0;
    int         rdlog0 [16];
    int         rdlog1 [16];
    int         nchk = 0, nerr = 0;
    int         base;
    logic       bad;

    uart_tx_stream #(.DBIT(8), .SB_TICK(16), .DVSR(4)) dut0 (
        .clk(clk), .reset(reset), .tx_en(en0), .fifo_empty(fifo_empty0),
        .fifo_r_data(fifo_data0), .fifo_rd(fifo_rd0), .tx(tx_w[0]), .tx_busy(busy_w[0])
    );

    uart_tx_stream #(.DBIT(8), .SB_TICK(32), .DVSR(2)) dut1 (
        .clk(clk), .reset(reset), .tx_en(en1), .fifo_empty(fifo_empty1),
        .fifo_r_data(fifo_data1), .fifo_rd(fifo_rd1), .tx(tx_w[1]), .tx_busy(busy_w[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pop strobes are sampled at the active edge and applied at the following negedge.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        pend0 <= fifo_rd0;
        pend1 <= fifo_rd1;
        if (fifo_rd0) begin
            chk("rd0_while_empty", fifo_empty0, 0);
            if (rdcnt0 < 16) rdlog0[rdcnt0] <= cyc;
            rdcnt0 <= rdcnt0 + 1;
        end
        if (fifo_rd1) begin
            chk("rd1_while_empty", fifo_empty1, 0);
            if (rdcnt1 < 16) rdlog1[rdcnt1] <= cyc;
            rdcnt1 <= rdcnt1 + 1;
        end
        if (reset) begin
            chk("rd0_in_reset", fifo_rd0, 0);
            chk("rd1_in_reset", fifo_rd1, 0);
        end
    end

    always @(negedge clk) begin
        if (pend0 && fifo0.size() > 0) void'(fifo0.pop_front());
        if (pend1 && fifo1.size() > 0) void'(fifo1.pop_front());
        #1;
        fifo_empty0 = (fifo0.size() == 0);
        fifo_data0  = (fifo0.size() > 0) ? fifo0[0] : 8'h00;
        fifo_empty1 = (fifo1.size() == 0);
        fifo_data1  = (fifo1.size() > 0) ? fifo1[0] : 8'h00;
    end

    task automatic push(input int i, input logic [7:0] w);
        @(negedge clk);
        if (i == 0) begin fifo0.push_back(w); exp0.push_back(w); end
        else        begin fifo1.push_back(w); exp1.push_back(w); end
    endtask

    task automatic mon(input int i, input int dvsr, input int sb);
        int per, tot, ph;
        logic [7:0] w, e;
        logic b, ok_s, ok_d, ok_p, ok_b, abort;
        per = 16 * dvsr;
        tot = 9 * per + sb * dvsr;
        forever begin
            @(negedge clk);
            if (tx_w[i] === 1'b0 && reset === 1'b0) begin
                ok_s = 1; ok_d = 1; ok_p = 1; ok_b = 1; abort = 0; w = '0; b = 1'b0;
                for (int k = 0; k < tot; k++) begin
                    if (k > 0) @(negedge clk);
                    if (reset !== 1'b0) begin abort = 1; break; end
                    ph = k / per;
                    if (busy_w[i] !== 1'b1) ok_b = 0;
                    if (ph == 0) begin
                        if (tx_w[i] !== 1'b0) ok_s = 0;
                    end else if (ph <= 8) begin
                        if (k % per == 0) begin b = tx_w[i]; w[ph-1] = b; end
                        else if (tx_w[i] !== b) ok_d = 0;
                    end else if (tx_w[i] !== 1'b1) ok_p = 0;
                end
                if (abort) begin
                    if (i == 0 && exp0.size() > 0) void'(exp0.pop_front());
                    if (i == 1 && exp1.size() > 0) void'(exp1.pop_front());
                end else begin
                    @(negedge clk);
                    chk("start_bit_low", ok_s, 1);
                    chk("data_bits_stable", ok_d, 1);
                    chk("stop_bit_high", ok_p, 1);
                    chk("busy_through_frame", ok_b, 1);
                    chk("busy_low_after_frame", busy_w[i], 0);
                    chk("tx_high_after_frame", tx_w[i], 1);
                    if ((i == 0 ? exp0.size() : exp1.size()) == 0) begin
                        chk("unexpected_frame", 0, 1);
                    end else begin
                        e = (i == 0) ? exp0.pop_front() : exp1.pop_front();
                        chk("frame_word", w, e);
                    end
                end
            end
        end
    endtask

    task automatic wait_done(input int i, input int budget);
        int n = 0;
        while (n < budget && !((i == 0 ? exp0.size() : exp1.size()) == 0 && busy_w[i] === 1'b0)) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("queue_drained", (i == 0) ? exp0.size() : exp1.size(), 0);
    endtask

    task automatic wait_rd0(input int target, input int budget);
        int n = 0;
        while (n < budget && rdcnt0 < target) begin
            @(negedge clk);
            n++;
        end
        chk("rd0_count_reached", rdcnt0, target);
    endtask

    initial begin
        fork
            mon(0, 4, 16);
            mon(1, 2, 32);
        join_none
    end

    initial begin
        #1 reset = 1'b1;
        push(0, 8'hA5);
        repeat (3) @(negedge clk);
        chk("reset_tx", tx_w[0], 1);
        chk("reset_busy", busy_w[0], 0);
        chk("reset_rd", fifo_rd0, 0);
        chk("reset_tx1", tx_w[1], 1);
        @(negedge clk) reset = 1'b0;

        // Single A5 frame
        wait_done(0, 2000);
        chk("a5_rd_pulses", rdcnt0, 1);

        // Three back-to-back words
        base = rdcnt0;
        push(0, 8'h01);
        push(0, 8'hFF);
        push(0, 8'h00);
        wait_done(0, 3000);
        chk("b2b_rd_pulses", rdcnt0, base + 3);
        chk("b2b_gap_1", rdlog0[base+1] - rdlog0[base], 641);
        chk("b2b_gap_2", rdlog0[base+2] - rdlog0[base+1], 641);

        // Empty FIFO keeps the line idle
        base = rdcnt0;
        bad = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || fifo_rd0 !== 1'b0) bad = 1'b1;
        end
        chk("idle_line", bad, 0);
        chk("idle_no_rd", rdcnt0, base);

        // tx_en dropped mid-frame
        base = rdcnt0;
        push(0, 8'h3C);
        push(0, 8'h5A);
        wait_rd0(base + 1, 50);
        repeat (100) @(negedge clk);
        en0 = 1'b0;
        for (int n = 0; n < 1000 && busy_w[0] !== 1'b0; n++) @(negedge clk);
        repeat (200) @(negedge clk);
        chk("no_rd_while_disabled", rdcnt0, base + 1);
        chk("pending_still_queued", exp0.size(), 1);
        @(negedge clk) en0 = 1'b1;
        @(negedge clk);
        chk("rd_on_enable", rdcnt0, base + 2);
        wait_done(0, 2000);

        // Asynchronous reset during DATA
        base = rdcnt0;
        push(0, 8'h96);
        push(0, 8'hC3);
        wait_rd0(base + 1, 50);
        repeat (100) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_tx", tx_w[0], 1);
        chk("async_reset_busy", busy_w[0], 0);
        repeat (3) @(negedge clk);
        chk("rd_low_in_reset", fifo_rd0, 0);
        @(negedge clk) reset = 1'b0;
        wait_done(0, 2000);
        chk("after_reset_rd_pulses", rdcnt0, base + 2);

        // Two stop bits at DVSR=2
        push(1, 8'h81);
        push(1, 8'h7E);
        wait_done(1, 2000);
        chk("sb32_rd_pulses", rdcnt1, 2);
        chk("sb32_gap", rdlog1[1] - rdlog1[0], 353);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/uart_tx_stream.md
UART_TX_STREAM -- requirements
Module: uart_tx_stream

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, stop-bit length in oversample ticks (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have parameter DVSR, default 163, clk cycles per oversample tick (16x oversampling), legal range 2..65535.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port tx_en  input  1  permit start of new frames.
REQ-007 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-008 SHALL have port fifo_r_data  input  DBIT  upstream FIFO head word, valid whenever fifo_empty=0 (first-word fall-through).
REQ-009 SHALL have port fifo_rd  output  1  single-cycle pop strobe to upstream FIFO.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port tx_busy  output  1  high while a frame is in progress.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP; only one state active at a time.
REQ-013 SHALL contain a tick generator: counter 0..DVSR-1, held at 0 in IDLE, tick = 1 for one clk when counter = DVSR-1, wrapping to 0.
REQ-014 In IDLE with tx_en=1 and fifo_empty=0, SHALL on that clk edge latch fifo_r_data into a DBIT-bit shift register and move to START; fifo_rd SHALL be high combinationally during exactly that one cycle.
REQ-015 fifo_rd SHALL never be asserted outside REQ-014 conditions, in particular never while fifo_empty=1 or outside IDLE.
REQ-016 START SHALL drive tx=0 for 16 ticks (16*DVSR clk), then move to DATA with bit counter 0.
REQ-017 DATA SHALL drive tx = shift register bit 0 (LSB first) for 16 ticks per bit, shifting right after each bit, moving to STOP after DBIT bits.
REQ-018 STOP SHALL drive tx=1 for SB_TICK ticks, then return to IDLE.
REQ-019 tx SHALL be a registered output; tx=1 in IDLE.
REQ-020 Frame duration from fifo_rd cycle to first IDLE cycle SHALL be exactly ((1+DBIT)*16 + SB_TICK)*DVSR clk cycles.
REQ-021 Back-to-back: with words pending and tx_en=1, the next fifo_rd SHALL occur on the first IDLE cycle, giving exactly one clk of idle-high between frames.
REQ-022 tx_en deasserted mid-frame SHALL NOT abort the frame; it only blocks the next start from IDLE.
REQ-023 Changes on fifo_r_data or fifo_empty after the latch cycle SHALL NOT affect the frame in progress.
REQ-024 tx_busy SHALL be 1 in START, DATA, STOP and 0 in IDLE.

Reset
REQ-025 reset=1 SHALL immediately, without clk, force state IDLE, tx=1, tx_busy=0, tick counter 0, bit counter 0, shift register 0.
REQ-026 fifo_rd SHALL be 0 while reset=1.
REQ-027 reset asserted mid-frame SHALL abandon the frame (word lost, no re-pop); after release the block SHALL start a new frame only per REQ-014.

Verification
REQ-028 DVSR=4, SB_TICK=16, FIFO holds 8'hA5, tx_en=1 -> one fifo_rd pulse; tx low 64 clk, then bits 1,0,1,0,0,1,0,1 each 64 clk, high 64 clk; tx_busy high 640 clk.
REQ-029 FIFO holds 8'h01, 8'hFF, 8'h00 -> three fifo_rd pulses spaced exactly 641 clk apart, frames decode to 01, FF, 00 in order.
REQ-030 fifo_empty=1 for 1000 clk -> fifo_rd never asserted, tx constantly 1, tx_busy 0.
REQ-031 tx_en dropped in the DATA state of a frame carrying 8'h3C -> frame completes intact, no further fifo_rd until tx_en=1 again, then next word popped on next IDLE cycle.
REQ-032 reset pulsed asynchronously (between clk edges) during DATA -> tx=1 and tx_busy=0 before the next clk edge, no fifo_rd during reset, next pending word transmitted cleanly after release.
REQ-033 SB_TICK=32, DVSR=2 -> stop bit high 64 clk, frame 352 clk, inter-frame gap 1 clk.
